// File: rtl/image_scanner.sv
// image_scanner: raster-sweeps an image RAM once per start and reports matches to a latched target colour.
// Revision 1.0
`default_nettype none

module image_scanner #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  target_color,
  output logic [7:0]  x,
  output logic [6:0]  y,
  input  logic [2:0]  image_color,
  output logic        busy,
  output logic        done,
  output logic [14:0] match_count,
  output logic        found,
  output logic [7:0]  first_x,
  output logic [6:0]  first_y
);

  localparam logic [7:0] X_LAST     = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST     = 7'(HEIGHT - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [14:0] cnt_q, cnt_d;
  logic        found_q, found_d;
  logic [7:0]  fx_q, fx_d;
  logic [6:0]  fy_q, fy_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Address delay line: stage RD_LAT-1 lines up with the pixel on image_color.
  logic        vld_q [RD_LAT];
  logic [7:0]  px_q  [RD_LAT];
  logic [6:0]  py_q  [RD_LAT];
  logic        pix_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= (state_q == SCAN);
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
    px_q[0] <= x_q;
    py_q[0] <= y_q;
    for (int i = 1; i < RD_LAT; i++) begin
      px_q[i] <= px_q[i-1];
      py_q[i] <= py_q[i-1];
    end
  end

  assign pix_hit = vld_q[RD_LAT-1] && (image_color == tgt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    dcnt_d  = dcnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target_color;
          cnt_d   = '0;
          found_d = 1'b0;
          fx_d    = '0;
          fy_d    = '0;
          x_d     = '0;
          y_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            dcnt_d  = '0;
            state_d = DRAIN;
          end else begin
            x_d = '0;
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DRAIN_LAST) state_d = DONE;
        else                      dcnt_d  = dcnt_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Only valid while draining/scanning, so never collides with the start clear.
    if (pix_hit) begin
      cnt_d = cnt_q + 15'd1;
      if (!found_q) begin
        found_d = 1'b1;
        fx_d    = px_q[RD_LAT-1];
        fy_d    = py_q[RD_LAT-1];
      end
    end

    busy_d = (state_d == SCAN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  assign x           = x_q;
  assign y           = y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = cnt_q;
  assign found       = found_q;
  assign first_x     = fx_q;
  assign first_y     = fy_q;

endmodule

`default_nettype wire

// File: doc/image_scanner.md
IMAGE_SCANNER -- requirements
Module: image_scanner

Interface
REQ-001 Parameter WIDTH, default 160, frame width in pixels; x sweeps 0..WIDTH-1.
REQ-002 Parameter HEIGHT, default 120, frame height in pixels; y sweeps 0..HEIGHT-1.
REQ-003 Parameter RD_LAT, default 1, cycles from address presented on x/y to data valid on image_color (legal values 1..3).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a full-frame scan.
REQ-007 target_color  input  3  colour to match; sampled on the accepted start cycle.
REQ-008 x  output  8  pixel column address driven to the image RAM processor port.
REQ-009 y  output  7  pixel row address driven to the image RAM processor port.
REQ-010 image_color  input  3  RAM read data for the address presented RD_LAT cycles earlier.
REQ-011 busy  output  1  high while a scan is in progress.
REQ-012 done  output  1  one-cycle pulse when scan results are final.
REQ-013 match_count  output  15  number of pixels equal to target_color in the last scan.
REQ-014 found  output  1  high if match_count is nonzero.
REQ-015 first_x  output  8  column of the first match in raster order.
REQ-016 first_y  output  7  row of the first match in raster order.

Function
REQ-017 States: IDLE, SCAN, DRAIN, DONE; reset enters IDLE.
REQ-018 IDLE: start=1 latches target_color, clears match_count/found/first_x/first_y, sets x=0,y=0, enters SCAN next cycle.
REQ-019 SCAN: one new address per cycle, raster order, x fastest; x wraps WIDTH-1->0 with y+1.
REQ-020 SCAN leaves after issuing (WIDTH-1,HEIGHT-1) and enters DRAIN; x/y hold last address thereafter.
REQ-021 Address (x,y) paired with image_color exactly RD_LAT cycles later via an RD_LAT-deep valid/x/y delay pipeline.
REQ-022 Each valid returned pixel equal to latched target increments match_count by 1; no saturation needed (max 19200 < 2^15).
REQ-023 First valid match only sets found=1 and loads first_x/first_y from delayed coordinates; later matches leave them unchanged.
REQ-024 DRAIN lasts until the delay pipeline is empty (RD_LAT cycles), then DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; results hold until next accepted start or reset.
REQ-026 busy=1 in SCAN and DRAIN only; 0 in IDLE and DONE.
REQ-027 start while busy or in DONE is ignored; start in IDLE on the cycle after done is accepted.
REQ-028 Latency: start accepted at cycle T -> done high at T+WIDTH*HEIGHT+RD_LAT+1.
REQ-029 target_color changes during a scan have no effect.
REQ-030 Outputs are registered; no combinational path from image_color to any output.

Reset
REQ-031 reset=1 on a clock edge forces IDLE, x=0, y=0, busy=0, done=0, match_count=0, found=0, first_x=0, first_y=0, clears delay-pipeline valid bits.
REQ-032 reset mid-scan aborts immediately; no done pulse is produced for the aborted scan.
REQ-033 reset has priority over start in the same cycle.

Verification
REQ-034 RAM model all colour 0, target 3'd2, start -> done at T+19202 (RD_LAT=1), match_count=0, found=0, first_x=0, first_y=0.
REQ-035 Single pixel (37,54)=3'd5, rest 0, target 5 -> match_count=1, found=1, first_x=37, first_y=54.
REQ-036 Pixels (159,0) and (0,1) = 3'd7, target 7 -> match_count=2, first_x=159, first_y=0 (row wrap boundary).
REQ-037 Whole frame 3'd4, target 4 -> match_count=19200, first_x=0, first_y=0; repeat with RD_LAT=3 -> identical results, done at T+19204.
REQ-038 Second start and target change at T+100 during scan -> ignored, results match single-scan values; reset at T+5000 -> busy=0 next cycle, no done, all outputs 0.
REQ-039 Scoreboard checks x/y raster sequence every SCAN cycle and busy/done timing against REQ-026/REQ-028.
